// File: rtl/seg7_scan_driver.sv
// Scanned common-anode 7-seg driver: shadow/display double buffer, one digit per REFRESH_DIV cycles.
// Outputs registered (update on prescaler tick); optional hex glyphs via SEG7_HEX_EN.
// No backpressure: load is a fire-and-forget strobe, newest value wins at the next frame boundary.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic [0:6]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shd_q, shd_d;
    logic [4*NUM_DIGITS-1:0] dsp_q, dsp_d;
    logic                    lz_q, lz_d;
    logic [0:6]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic                    tick;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   zrun;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [3:0]              nib;
    logic                    blank;

    function automatic logic [0:6] decode(input logic [3:0] n);
        logic [0:6] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
`ifdef SEG7_HEX_EN
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b1100000;
            4'd12:   s = 7'b0110001;
            4'd13:   s = 7'b1000010;
            4'd14:   s = 7'b0110000;
            4'd15:   s = 7'b0111000;
`endif
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        tick     = (pre_q == PRE_MAX);
        pre_d    = tick ? '0 : pre_q + 1'b1;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        boundary = tick && (idx_d == '0);

        shd_d = load ? value : shd_q;
        dsp_d = boundary ? shd_q : dsp_q;
        lz_d  = boundary ? blank_lz : lz_q;
        fd_d  = boundary;

        // zrun[i]: nibbles i..top of the post-boundary word are all zero
        zrun = '0;
        zrun[NUM_DIGITS-1] = (dsp_d[4*(NUM_DIGITS-1) +: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zrun[i] = zrun[i+1] && (dsp_d[4*i +: 4] == 4'd0);
        end

        nib   = '0;
        blank = 1'b0;
        an_n  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib     = dsp_d[4*i +: 4];
                blank   = lz_d && (i > 0) && zrun[i];
                an_n[i] = 1'b0;
            end
        end

        seg_d = seg_q;
        an_d  = an_q;
        if (tick) begin
            seg_d = blank ? 7'b1111111 : decode(nib);
            an_d  = an_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= IDX_MAX;
            shd_q <= '0;
            dsp_q <= '0;
            lz_q  <= 1'b0;
            seg_q <= 7'b1111111;
            an_q  <= '1;
            fd_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            shd_q <= shd_d;
            dsp_q <= dsp_d;
            lz_q  <= lz_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            fd_q  <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4; hex expectations follow SEG7_HEX_EN.
module tb_seg7_scan_driver;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0001100;
    localparam logic [6:0] GB = 7'b1111111;
`ifdef SEG7_HEX_EN
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0111000;
`else
    localparam logic [6:0] GA = 7'b1111111;
    localparam logic [6:0] GF = 7'b1111111;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        blank_lz = 1'b0;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        blz;
        logic [15:0] val;
        logic [6:0]  e0, e1, e2, e3;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(logic b, logic [15:0] v, logic [6:0] a0, logic [6:0] a1,
                                logic [6:0] a2, logic [6:0] a3);
        vec_t r;
        r.blz = b; r.val = v; r.e0 = a0; r.e1 = a1; r.e2 = a2; r.e3 = a3;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (frame_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: frame_done timeout got 0 expected 1", name);
        end
    endtask

    function automatic logic [3:0] an_exp(int d);
        logic [3:0] one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic chk_digit(input string name, input int d, input logic [6:0] e);
        chk({name, " seg"}, {25'd0, seg}, {25'd0, e});
        chk({name, " an"}, {28'd0, an}, {28'd0, an_exp(d)});
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        step();
        load  = 1'b0;
    endtask

    initial begin
        logic [6:0] e;
        int         cnt;

        vecs[0] = mk(1'b0, 16'h1234, G4, G3, G2, G1);
        vecs[1] = mk(1'b1, 16'h0007, G7, GB, GB, GB);
        vecs[2] = mk(1'b1, 16'h0000, G0, GB, GB, GB);
        vecs[3] = mk(1'b0, 16'h0000, G0, G0, G0, G0);
        vecs[4] = mk(1'b1, 16'h0100, G0, G0, G1, GB);
        vecs[5] = mk(1'b0, 16'h00AF, GF, GA, G0, G0);
        vecs[6] = mk(1'b1, 16'h00A0, G0, GA, GB, GB);
        vecs[7] = mk(1'b1, 16'h9080, G0, G8, G0, G9);

        // reset state and first tick at edge 4
        repeat (3) step();
        chk("rst seg", {25'd0, seg}, {25'd0, GB});
        chk("rst an", {28'd0, an}, 32'hF);
        chk("rst fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) begin
                chk($sformatf("pre-tick an e%0d", k), {28'd0, an}, 32'hF);
                chk($sformatf("pre-tick fd e%0d", k), {31'd0, frame_done}, 32'd0);
            end
        end
        chk("first tick fd", {31'd0, frame_done}, 32'd1);
        chk_digit("first tick", 0, G0);

        // frame_done period
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt++;
            if (frame_done === 1'b1) break;
        end
        chk("fd period", cnt, 32'd16);

        // table-driven frames
        for (int v = 0; v < 8; v++) begin
            wait_fd($sformatf("v%0d pre", v));
            blank_lz = vecs[v].blz;
            do_load(vecs[v].val);
            wait_fd($sformatf("v%0d show", v));
            for (int d = 0; d < 4; d++) begin
                case (d)
                    0: e = vecs[v].e0;
                    1: e = vecs[v].e1;
                    2: e = vecs[v].e2;
                    default: e = vecs[v].e3;
                endcase
                chk_digit($sformatf("v%0d d%0d start", v, d), d, e);
                if (d == 0) chk($sformatf("v%0d fd hi", v), {31'd0, frame_done}, 32'd1);
                repeat (3) step();
                chk_digit($sformatf("v%0d d%0d end", v, d), d, e);
                chk($sformatf("v%0d d%0d fd lo", v, d), {31'd0, frame_done}, 32'd0);
                if (d < 3) step();
            end
        end

        // deferred load mid-frame
        blank_lz = 1'b0;
        wait_fd("defer pre");
        do_load(16'h1234);
        wait_fd("defer base");
        repeat (5) step();
        do_load(16'h5678);
        repeat (2) step();
        chk_digit("defer d2 old", 2, G2);
        repeat (4) step();
        chk_digit("defer d3 old", 3, G1);
        repeat (4) step();
        chk("defer fd", {31'd0, frame_done}, 32'd1);
        chk_digit("defer new d0", 0, G8);
        repeat (4) step();
        chk_digit("defer new d1", 1, G7);
        repeat (4) step();
        chk_digit("defer new d2", 2, G6);
        repeat (4) step();
        chk_digit("defer new d3", 3, G5);

        // load landing exactly on the boundary edge
        repeat (3) step();
        load  = 1'b1;
        value = 16'h0009;
        step();
        load  = 1'b0;
        chk("bnd-load fd", {31'd0, frame_done}, 32'd1);
        chk_digit("bnd-load old d0", 0, G8);
        wait_fd("bnd-load next");
        chk_digit("bnd-load new d0", 0, G9);
        repeat (4) step();
        chk_digit("bnd-load new d1", 1, G0);

        // asynchronous reset while digit 2 active
        repeat (4) step();
        chk("mid-rst pre an", {28'd0, an}, {28'd0, an_exp(2)});
        do_load(16'h4444);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst seg", {25'd0, seg}, {25'd0, GB});
        chk("mid-rst an", {28'd0, an}, 32'hF);
        chk("mid-rst fd", {31'd0, frame_done}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post-rst an", {28'd0, an}, 32'hF);
        step();
        chk("post-rst fd", {31'd0, frame_done}, 32'd1);
        chk_digit("post-rst d0", 0, G0);
        repeat (4) step();
        chk_digit("post-rst d1", 1, G0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

- Time-multiplexed driver for a bank of `NUM_DIGITS` common-anode seven-segment digits.
- Captures a packed BCD word, scans one digit at a time at a programmable refresh rate, and drives shared active-low segment lines plus active-low digit enables.
- Optional leading-zero blanking.
- Sits between the datapath that produces BCD results and the board display pins.
- Replaces per-digit combinational decoders on the display path.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled; legal minimum 2.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load`  in  1  one-cycle strobe; capture `value` into the shadow register.
- `value`  in  `4*NUM_DIGITS`  packed BCD; `value[3:0]` is digit 0, the least significant digit.
- `blank_lz`  in  1  enable leading-zero blanking.
- `seg`  out  `[0:6]`  segments a..g, index 0 = a; 0 = lit.
- `an`  out  `NUM_DIGITS`  digit enables, active-low; `an[i]` enables digit i.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - prescaler `pre`, width `$clog2(REFRESH_DIV)`;
  - digit index `idx`;
  - shadow word `shd`;
  - display word `dsp`;
  - latched `lz`;
  - registered `seg`, `an`, `frame_done`.
- Tick: `pre == REFRESH_DIV-1`. On a tick, `pre` returns to 0; otherwise `pre` increments.
- On tick, `idx` advances: `NUM_DIGITS-1` wraps to 0, otherwise increments.
- Frame boundary: a tick where the new `idx` is 0. At that edge:
  - `dsp <= shd` (pre-edge value of `shd`);
  - `lz <= blank_lz`;
  - `frame_done <= 1`.
- `frame_done` is 0 on every other cycle.
- `load=1` at any edge: `shd <= value`. The displayed value changes only at the next frame boundary, which prevents tearing. A load on the boundary edge itself is not shown until the following frame.
- On every tick, `an` gets all ones except bit `idx_new`, which is 0. `seg` gets the decode of nibble `dsp_new[4*idx_new +: 4]`. `dsp_new` is the post-boundary value, so digit 0 of a new frame shows the new word.
- Decode (`seg[0:6]`):
  - 0 → 0000001
  - 1 → 1001111
  - 2 → 0010010
  - 3 → 0000110
  - 4 → 1001100
  - 5 → 0100100
  - 6 → 0100000
  - 7 → 0001111
  - 8 → 0000000
  - 9 → 0001100
  - 10–15 → see Configuration.
- Leading-zero blanking:
  - Applies when `lz=1` and `NUM_DIGITS>1`.
  - Digit i (i ≥ 1) is blank (`seg=1111111`, `an` still asserted) if nibbles i..`NUM_DIGITS-1` of `dsp` are all zero.
  - Digit 0 is never blanked.
- `NUM_DIGITS=1`: `idx` is constant 0, and every tick is a frame boundary.

## Timing
- Reset values (asynchronous, held while `rst_n=0`):
  - `pre=0`, `idx=NUM_DIGITS-1`;
  - `shd=0`, `dsp=0`, `lz=0`;
  - `seg=1111111`, `an` all ones, `frame_done=0`.
- After `rst_n` deasserts, the first tick occurs on edge `REFRESH_DIV`: digit 0 is enabled and `frame_done` pulses.
- Each digit is enabled for exactly `REFRESH_DIV` cycles. A frame lasts `NUM_DIGITS*REFRESH_DIV` cycles.
- Exactly one `an` bit is low at any time after the first tick.
- Load-to-display latency: at most one frame plus one cycle.
- Reset asserted mid-frame: all state returns to reset values immediately, and the pending `shd` is discarded.

## Configuration
- `SEG7_HEX_EN` defined: nibbles 10–15 decode to hex glyphs:
  - A → 0001000
  - b → 1100000
  - C → 0110001
  - d → 1000010
  - E → 0110000
  - F → 0111000
- `SEG7_HEX_EN` undefined: nibbles 10–15 decode to blank, 1111111.
- Leading-zero blanking tests only for nibble value zero, independent of the macro.

## Test plan
- Reset: with `NUM_DIGITS=4`, `REFRESH_DIV=4`, hold `rst_n=0` → `seg=1111111`, `an=1111`, `frame_done=0`. Release → first `an=1110` and a `frame_done` pulse at edge 4.
- Scan: load 0x1234, then wait one frame → digits 0..3 show 4,3,2,1 with `an` 1110,1101,1011,0111, 4 cycles each. `frame_done` period is 16 cycles.
- Blanking: `blank_lz=1`, load 0x0007 → digit 0 = 0001111, digits 1–3 = 1111111. Load 0x0000 → digit 0 = 0000001, digits 1–3 blank. With `blank_lz=0` → digits 1–3 = 0000001.
- Deferred load: load 0x5678 mid-frame, while digit 1 is active → digits 2 and 3 still show the old word. The next frame shows 8,7,6,5. A load on the boundary edge is delayed one further frame.
- Hex: load 0x00AF → digit 0 = 0111000 and digit 1 = 0001000 with `SEG7_HEX_EN`; both 1111111 without it.
- Reset mid-frame: assert `rst_n=0` while digit 2 is active → outputs go to reset values asynchronously. After release, the display restarts at digit 0 showing 0.
